// File: rtl/ex_pkg.sv
// Shared encodings for the EX stage: ALU ops, MDU ops, HI/LO read,
// forwarding selects and the MDU state encoding.
package ex_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_NOR  = 4'd5;
  localparam logic [3:0] ALU_SLT  = 4'd6;
  localparam logic [3:0] ALU_SLTU = 4'd7;
  localparam logic [3:0] ALU_SLL  = 4'd8;
  localparam logic [3:0] ALU_SRL  = 4'd9;
  localparam logic [3:0] ALU_SRA  = 4'd10;
  localparam logic [3:0] ALU_LUI  = 4'd11;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam logic [1:0] HR_NONE = 2'd0;
  localparam logic [1:0] HR_HI   = 2'd1;
  localparam logic [1:0] HR_LO   = 2'd2;

  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_WB  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_t;

endpackage

// File: rtl/ex_stage_mdu_mdu_iter.sv
// Iterative multiply/divide unit with HI/LO registers.
// Ports: md_op/src_a/src_b/stall/flush in; hi, lo, busy out. Macro MDU_FASTMUL_EN.
module mdu_iter
  import ex_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [2:0]      md_op,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  input  logic            stall,
  input  logic            flush,
  output logic [XLEN-1:0] hi,
  output logic [XLEN-1:0] lo,
  output logic            busy
);

  localparam int MD_CYCLES = XLEN;
  localparam int CW = $clog2(MD_CYCLES) + 1;

  md_state_t state, state_n;

  logic [2:0]      op_q;
  logic            sa_q, sb_q;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] p_hi, p_lo;
  logic [CW-1:0]   cnt;

  logic            is_md, is_mv, launch, move, sgn_op;
  logic            sa, sb, fast_go, mul_q;
  logic [XLEN-1:0] a_mag, b_mag;
  logic [XLEN:0]   mul_sum, div_sh, div_diff;
  logic [2*XLEN-1:0] prod, prod_fix, fast_prod;
  logic [XLEN-1:0] q_fix, r_fix;

  assign is_md  = (md_op == MD_MULT) | (md_op == MD_MULTU) |
                  (md_op == MD_DIV)  | (md_op == MD_DIVU);
  assign is_mv  = (md_op == MD_MTHI) | (md_op == MD_MTLO);
  assign launch = is_md & ~stall & ~flush;
  assign move   = is_mv & ~stall & ~flush;
  assign sgn_op = (md_op == MD_MULT) | (md_op == MD_DIV);
  assign sa     = sgn_op & src_a[XLEN-1];
  assign sb     = sgn_op & src_b[XLEN-1];
  assign a_mag  = sa ? -src_a : src_a;
  assign b_mag  = sb ? -src_b : src_b;

`ifdef MDU_FASTMUL_EN
  assign fast_go   = (md_op == MD_MULT) | (md_op == MD_MULTU);
  assign fast_prod = a_mag * b_mag;
`else
  assign fast_go   = 1'b0;
  assign fast_prod = '0;
`endif

  assign mul_q = (op_q == MD_MULT) | (op_q == MD_MULTU);

  // Shift-add: accumulate into p_hi, multiplier shifts out of p_lo.
  assign mul_sum = {1'b0, p_hi} + (p_lo[0] ? {1'b0, mcand} : '0);

  // Restoring divide: p_hi is the partial remainder, p_lo the
  // dividend shifting out / quotient shifting in.
  assign div_sh   = {p_hi, p_lo[XLEN-1]};
  assign div_diff = div_sh - {1'b0, mcand};

  assign prod     = {p_hi, p_lo};
  assign prod_fix = (sa_q ^ sb_q) ? -prod : prod;
  assign q_fix    = (sa_q ^ sb_q) ? -p_lo : p_lo;
  // A zero divisor leaves the whole dividend magnitude as remainder,
  // so r_fix already equals the dividend; only LO needs forcing.
  assign r_fix    = sa_q ? -p_hi : p_hi;

  assign busy = (state != MD_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= MD_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      MD_IDLE: if (launch) state_n = fast_go ? MD_FIX : MD_RUN;
      MD_RUN:  if (cnt == CW'(MD_CYCLES - 1)) state_n = MD_FIX;
      MD_FIX:  state_n = MD_IDLE;
      default: state_n = MD_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q  <= MD_NONE;
      sa_q  <= 1'b0;
      sb_q  <= 1'b0;
      mcand <= '0;
      p_hi  <= '0;
      p_lo  <= '0;
      cnt   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      unique case (state)
        MD_IDLE: begin
          if (launch) begin
            op_q  <= md_op;
            sa_q  <= sa;
            sb_q  <= sb;
            mcand <= b_mag;
            cnt   <= '0;
            if (fast_go) begin
              {p_hi, p_lo} <= fast_prod;
            end else begin
              p_hi <= '0;
              p_lo <= a_mag;
            end
          end else if (move) begin
            if (md_op == MD_MTHI) hi <= src_a;
            else                  lo <= src_a;
          end
        end
        MD_RUN: begin
          cnt <= cnt + CW'(1);
          if (mul_q) begin
            {p_hi, p_lo} <= {mul_sum, p_lo[XLEN-1:1]};
          end else begin
            p_lo <= {p_lo[XLEN-2:0], ~div_diff[XLEN]};
            p_hi <= div_diff[XLEN] ? div_sh[XLEN-1:0]
                                   : div_diff[XLEN-1:0];
          end
        end
        MD_FIX: begin
          if (mul_q) begin
            {hi, lo} <= prod_fix;
          end else begin
            hi <= r_fix;
            lo <= (mcand == '0) ? '1 : q_fix;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/ex_stage_mdu.sv
// MIPS execute stage: forwarding, ALU, dest select, plus iterative MDU.
// Ports: ID/EX controls and operands in; alu_out, write_data, write_reg, md_busy, stall out.
// Optional macro MDU_FASTMUL_EN selects single-cycle multiply.
module ex_stage_mdu
  import ex_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [3:0]         alu_ctrl,
  input  logic               alu_src,
  input  logic               alu_a_src,
  input  logic               reg_dst,
  input  logic [XLEN-1:0]    rd1,
  input  logic [XLEN-1:0]    rd2,
  input  logic [RADDR_W-1:0] rt,
  input  logic [RADDR_W-1:0] rd,
  input  logic [XLEN-1:0]    sign_imm,
  input  logic [4:0]         shamt,
  input  logic [XLEN-1:0]    alu_out_m,
  input  logic [XLEN-1:0]    result_w,
  input  logic [1:0]         fwd_a,
  input  logic [1:0]         fwd_b,
  input  logic [2:0]         md_op,
  input  logic [1:0]         hilo_rd,
  input  logic               flush,
  output logic [XLEN-1:0]    alu_out,
  output logic [XLEN-1:0]    write_data,
  output logic [RADDR_W-1:0] write_reg,
  output logic               md_busy,
  output logic               stall
);

  logic [XLEN-1:0] fa, src_a, src_b, alu_res, hi, lo;
  logic [4:0]      sh;
  logic            hr_use;

  // Reserved select 3 falls back to the register file.
  always_comb begin
    unique case (fwd_a)
      FWD_WB:  fa = result_w;
      FWD_MEM: fa = alu_out_m;
      default: fa = rd1;
    endcase
  end

  always_comb begin
    unique case (fwd_b)
      FWD_WB:  write_data = result_w;
      FWD_MEM: write_data = alu_out_m;
      default: write_data = rd2;
    endcase
  end

  assign src_a     = alu_a_src ? {{(XLEN-5){1'b0}}, shamt} : fa;
  assign src_b     = alu_src ? sign_imm : write_data;
  assign write_reg = reg_dst ? rd : rt;
  assign sh        = src_a[4:0];

  always_comb begin
    unique case (alu_ctrl)
      ALU_ADD:  alu_res = src_a + src_b;
      ALU_SUB:  alu_res = src_a - src_b;
      ALU_AND:  alu_res = src_a & src_b;
      ALU_OR:   alu_res = src_a | src_b;
      ALU_XOR:  alu_res = src_a ^ src_b;
      ALU_NOR:  alu_res = ~(src_a | src_b);
      ALU_SLT:  alu_res = {{(XLEN-1){1'b0}},
                           $signed(src_a) < $signed(src_b)};
      ALU_SLTU: alu_res = {{(XLEN-1){1'b0}}, src_a < src_b};
      ALU_SLL:  alu_res = src_b << sh;
      ALU_SRL:  alu_res = src_b >> sh;
      ALU_SRA:  alu_res = $unsigned($signed(src_b) >>> sh);
      ALU_LUI:  alu_res = src_b << 16;
      default:  alu_res = '0;
    endcase
  end

  always_comb begin
    unique case (hilo_rd)
      HR_HI:   alu_out = hi;
      HR_LO:   alu_out = lo;
      default: alu_out = alu_res;
    endcase
  end

  assign hr_use = (hilo_rd == HR_HI) | (hilo_rd == HR_LO);
  assign stall  = md_busy & ((md_op != MD_NONE) | hr_use);

  mdu_iter #(.XLEN(XLEN)) u_mdu (
    .clk   (clk),
    .rst_n (rst_n),
    .md_op (md_op),
    .src_a (src_a),
    .src_b (write_data),
    .stall (stall),
    .flush (flush),
    .hi    (hi),
    .lo    (lo),
    .busy  (md_busy)
  );

endmodule
